// File: rtl/load_store_unit.sv
//----------------------------------------------------------------------------
// load_store_unit
//
// Executes one LDR/STR (word or byte, pre/post-indexed, add/subtract offset,
// optional base writeback) per request from the execute stage. Operands are
// captured on start. When the instruction condition passed, the unit performs
// a single memory access and then writes back Rd and/or Rn for one cycle.
// A down-counter bounds the wait for mem_ack. If it expires, the access is
// abandoned and a fault pulse is raised together with done.
//
// Parameters
//   ACK_TIMEOUT  ACCESS cycles allowed without mem_ack before faulting
//
// Ports
//   clk, nreset                 clock, synchronous active-high reset
//   start, cond_pass            request strobe and condition result
//   load, pre_index, up,        instruction attributes (L, P, U, B, W)
//   byte_op, writeback
//   base, offset, store_data    Rn value, offset, Rd value for stores
//   rd_in, rn_in                register indices
//   mem_req/we/addr/be/wdata    memory request, held until mem_ack
//   mem_ack, mem_rdata          memory completion and read data
//   rd_we/rd_addr/rd_data       Rd write port (loads)
//   rn_we/rn_addr/rn_data       Rn write port (base update)
//   busy, done, fault           status: in progress, completion, timeout
//----------------------------------------------------------------------------
`timescale 1ns/1ps

module load_store_unit #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        start,
    input  logic        cond_pass,
    input  logic        load,
    input  logic        pre_index,
    input  logic        up,
    input  logic        byte_op,
    input  logic        writeback,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] store_data,
    input  logic [3:0]  rd_in,
    input  logic [3:0]  rn_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rd_we,
    output logic [3:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        rn_we,
    output logic [3:0]  rn_addr,
    output logic [31:0] rn_data,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    // state    | meaning
    // ---------+--------------------------------------------------------
    // IDLE     | waiting for start; outputs quiet
    // ACCESS   | mem_req held, waiting for mem_ack or timeout
    // COMPLETE | one cycle: done pulse, Rd/Rn writes if condition passed
    // FAULT    | one cycle: done and fault pulse, no register writes

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_COMPLETE = 2'd2,
        S_FAULT    = 2'd3
    } state_t;

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   ld_data_q, ld_data_d;

    logic          cond_q;
    logic          load_q;
    logic          byte_q;
    logic          rn_upd_q;
    logic [31:0]   addr_q;
    logic [31:0]   eff_q;
    logic [31:0]   sdata_q;
    logic [3:0]    rd_q;
    logic [3:0]    rn_q;

    logic [31:0]   eff_calc;
    logic [31:0]   rot_data;
    logic          accept;

    assign accept   = (state_q == S_IDLE) && start;
    assign eff_calc = up ? (base + offset) : (base - offset);

    // Rotating the read word right by the byte lane yields the unaligned
    // word result directly; its low byte is also the selected byte lane.
    assign rot_data = 32'({mem_rdata, mem_rdata} >> {addr_q[1:0], 3'b000});

    // Operand capture
    always_ff @(posedge clk) begin
        if (nreset) begin
            cond_q   <= 1'b0;
            load_q   <= 1'b0;
            byte_q   <= 1'b0;
            rn_upd_q <= 1'b0;
            addr_q   <= '0;
            eff_q    <= '0;
            sdata_q  <= '0;
            rd_q     <= '0;
            rn_q     <= '0;
        end else if (accept) begin
            cond_q   <= cond_pass;
            load_q   <= load;
            byte_q   <= byte_op;
            // post-indexed forms always update the base
            rn_upd_q <= writeback | ~pre_index;
            addr_q   <= pre_index ? eff_calc : base;
            eff_q    <= eff_calc;
            sdata_q  <= store_data;
            rd_q     <= rd_in;
            rn_q     <= rn_in;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (nreset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ld_data_d = ld_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = cond_pass ? S_ACCESS : S_COMPLETE;
                    // terminal count 0 lands on the last allowed ACCESS cycle
                    cnt_d   = CW'(ACK_TIMEOUT - 1);
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    state_d   = S_COMPLETE;
                    ld_data_d = byte_q ? {24'h0, rot_data[7:0]} : rot_data;
                end else if (cnt_q == '0) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_COMPLETE: state_d = S_IDLE;
            S_FAULT:    state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy      = 1'b1;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_be    = '0;
        mem_wdata = '0;
        done      = 1'b0;
        fault     = 1'b0;
        rd_we     = 1'b0;
        rd_addr   = '0;
        rd_data   = '0;
        rn_we     = 1'b0;
        rn_addr   = '0;
        rn_data   = '0;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
            end
            S_ACCESS: begin
                mem_req   = 1'b1;
                mem_we    = ~load_q;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_be    = byte_q ? (4'b0001 << addr_q[1:0]) : 4'b1111;
                mem_wdata = byte_q ? {4{sdata_q[7:0]}} : sdata_q;
            end
            S_COMPLETE: begin
                done = 1'b1;
                if (cond_q) begin
                    if (load_q) begin
                        rd_we   = 1'b1;
                        rd_addr = rd_q;
                        rd_data = ld_data_q;
                    end
                    // a load into the base register keeps the loaded value
                    if (rn_upd_q && !(load_q && (rd_q == rn_q))) begin
                        rn_we   = 1'b1;
                        rn_addr = rn_q;
                        rn_data = eff_q;
                    end
                end
            end
            S_FAULT: begin
                done  = 1'b1;
                fault = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
